// File: rtl/adc_spi_rx.sv
// SPI read-back master for a 16-bit ADC: convst pulse, cs/sck generation, MSB-first capture.
// Latency: data_valid fires T_CONV + 34*CLK_DIV clk edges after the edge that samples start.
// No backpressure: start is dropped while busy; key_state low aborts and clears everything.
module adc_spi_rx #(
  parameter int CLK_DIV = 4,
  parameter int T_CONV  = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_state,
  input  logic        start,
  input  logic        sdo,
  output logic        convst,
  output logic        cs,
  output logic        sck,
  output logic [4:0]  cnt_sck,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CONV  = 3'd1;
  localparam logic [2:0] SETUP = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  // Phase counter must reach the longer of the conversion wait and the sck half-period.
  localparam int CW = $clog2((T_CONV > CLK_DIV) ? T_CONV : CLK_DIV) + 1;
  localparam logic [CW-1:0] CONV_LAST = CW'(T_CONV - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);

  logic [2:0]    state;
  logic [CW-1:0] phase;
  logic [15:0]   shreg;
  logic          div_last;

  assign div_last = (phase == DIV_LAST);
  assign busy     = (state != IDLE);

  // Frame sequencer: every output is a register so cs/sck/convst are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= '0;
      shreg      <= '0;
      convst     <= 1'b0;
      cs         <= 1'b1;
      sck        <= 1'b0;
      cnt_sck    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (!key_state) begin
      // Disable discards any partial frame and wipes the last sample.
      state      <= IDLE;
      phase      <= '0;
      shreg      <= '0;
      convst     <= 1'b0;
      cs         <= 1'b1;
      sck        <= 1'b0;
      cnt_sck    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          cs  <= 1'b1;
          sck <= 1'b0;
          if (start) begin
            state  <= CONV;
            convst <= 1'b1;
            phase  <= '0;
          end
        end
        CONV: begin
          // convst spans the first two CONV cycles; T_CONV >= 3 guarantees it drops here.
          if (phase == CW'(1)) convst <= 1'b0;
          if (phase == CONV_LAST) begin
            cs    <= 1'b0;
            state <= SETUP;
            phase <= '0;
          end else begin
            phase <= phase + CW'(1);
          end
        end
        SETUP: begin
          if (div_last) begin
            state <= SHIFT;
            phase <= '0;
          end else begin
            phase <= phase + CW'(1);
          end
        end
        SHIFT: begin
          if (div_last) begin
            phase <= '0;
            sck   <= ~sck;
            if (!sck) begin
              // Rising toggle: sdo has been stable for a full half-period since the fall.
              shreg   <= {shreg[14:0], sdo};
              cnt_sck <= cnt_sck + 5'd1;
            end else if (cnt_sck == 5'd16) begin
              state <= HOLD;
            end
          end else begin
            phase <= phase + CW'(1);
          end
        end
        HOLD: begin
          if (div_last) begin
            cs         <= 1'b1;
            data_out   <= shreg;
            data_valid <= 1'b1;
            cnt_sck    <= '0;
            state      <= IDLE;
            phase      <= '0;
          end else begin
            phase <= phase + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          phase <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_rx.sv
// Bench for adc_spi_rx: default build plus a CLK_DIV=2 / T_CONV=3 build.
// Behavioural ADCs drive sdo from observed cs/sck edges.
// Frames are checked for data, latency, sck count, cs-low length and convst width.
module tb_adc_spi_rx;

  logic clk = 1'b0;
  logic rst_n, key_state, start, b_start;
  logic sdo = 1'b0;
  logic b_sdo = 1'b0;

  logic        convst, cs, sck, data_valid, busy;
  logic [4:0]  cnt_sck;
  logic [15:0] data_out;
  logic        b_convst, b_cs, b_sck, b_valid, b_busy;
  logic [4:0]  b_cnt;
  logic [15:0] b_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] adc_word = 16'h0;
  logic [15:0] b_word   = 16'h0;

  always #5 clk = ~clk;

  adc_spi_rx dut (
    .clk(clk), .rst_n(rst_n), .key_state(key_state), .start(start), .sdo(sdo),
    .convst(convst), .cs(cs), .sck(sck), .cnt_sck(cnt_sck), .data_out(data_out),
    .data_valid(data_valid), .busy(busy)
  );

  adc_spi_rx #(.CLK_DIV(2), .T_CONV(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_state(key_state), .start(b_start), .sdo(b_sdo),
    .convst(b_convst), .cs(b_cs), .sck(b_sck), .cnt_sck(b_cnt), .data_out(b_data),
    .data_valid(b_valid), .busy(b_busy)
  );

  // ADC model A: presents MSB on cs fall, next bit after each sck fall; plus edge counters.
  int n_rise = 0, n_cslow = 0, n_convst = 0, n_valid = 0, idx = 0;
  logic cs_q = 1'b1, sck_q = 1'b0;
  always @(negedge clk) begin
    if (cs_q && !cs) begin
      idx = 15;
      sdo = adc_word[15];
    end else if (sck_q && !sck && !cs) begin
      idx--;
      if (idx >= 0) sdo = adc_word[idx[3:0]];
    end
    if (!sck_q && sck) n_rise++;
    if (!cs) n_cslow++;
    if (convst) n_convst++;
    if (data_valid) n_valid++;
    cs_q  = cs;
    sck_q = sck;
  end

  // ADC model B with sck period measurement.
  int cyc = 0, b_rise = 0, b_cslow = 0, b_idx = 0, b_last_rise = 0, b_period = 0;
  logic b_cs_q = 1'b1, b_sck_q = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (b_cs_q && !b_cs) begin
      b_idx = 15;
      b_sdo = b_word[15];
    end else if (b_sck_q && !b_sck && !b_cs) begin
      b_idx--;
      if (b_idx >= 0) b_sdo = b_word[b_idx[3:0]];
    end
    if (!b_sck_q && b_sck) begin
      b_rise++;
      b_period    = cyc - b_last_rise;
      b_last_rise = cyc;
    end
    if (!b_cs) b_cslow++;
    b_cs_q  = b_cs;
    b_sck_q = b_sck;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues start from #1 after an edge, then waits (bounded) for data_valid.
  task automatic frame_a(input logic [15:0] w, input logic extra,
                         output int lat, output int gaps, output logic busy_at_valid);
    adc_word      = w;
    lat           = -1;
    gaps          = 0;
    busy_at_valid = 1'b1;
    start         = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (!busy) gaps++;
    for (int k = 1; k <= 400; k++) begin
      if (extra && (k == 10 || k == 100)) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (data_valid) begin
        lat           = k;
        busy_at_valid = busy;
        break;
      end
      if (!busy) gaps++;
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic        extra;
    int          lat;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, gaps, r0, c0, v0, vt0, k;
    logic bav;

    vecs[0] = '{16'hA5C3, 1'b0, 186, 16'hA5C3};
    vecs[1] = '{16'h0000, 1'b0, 186, 16'h0000};
    vecs[2] = '{16'hFFFF, 1'b0, 186, 16'hFFFF};
    vecs[3] = '{16'h8001, 1'b0, 186, 16'h8001};
    vecs[4] = '{16'h6E19, 1'b1, 186, 16'h6E19};

    rst_n = 1'b0; key_state = 1'b1; start = 1'b0; b_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_convst", 32'(convst), 32'd0);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_cnt_sck", 32'(cnt_sck), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: first vector standalone, rest back-to-back; last one gets extra starts.
    vt0 = n_valid;
    for (int i = 0; i < 5; i++) begin
      r0 = n_rise; c0 = n_cslow; v0 = n_convst;
      frame_a(vecs[i].word, vecs[i].extra, lat, gaps, bav);
      check($sformatf("v%0d_data", i), 32'(data_out), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_sck_rises", i), 32'(n_rise - r0), 32'd16);
      check($sformatf("v%0d_cs_low", i), 32'(n_cslow - c0), 32'd136);
      check($sformatf("v%0d_convst_len", i), 32'(n_convst - v0), 32'd2);
      check($sformatf("v%0d_busy_gaps", i), 32'(gaps), 32'd0);
      check($sformatf("v%0d_busy_at_valid", i), 32'(bav), 32'd0);
    end
    repeat (30) @(posedge clk);
    #1;
    check("extra_start_idle", 32'(busy), 32'd0);
    check("frame_count", 32'(n_valid - vt0), 32'd5);
    check("data_hold", 32'(data_out), 32'h6E19);

    // key_state drop after 7 sck rises.
    frame_a(16'h1234, 1'b0, lat, gaps, bav);
    check("pre_drop_data", 32'(data_out), 32'h1234);
    adc_word = 16'h5555;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (cnt_sck != 5'd7 && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drop_reached_7", 32'(cnt_sck), 32'd7);
    v0 = n_valid;
    key_state = 1'b0;
    @(posedge clk);
    #1;
    check("drop_cs", 32'(cs), 32'd1);
    check("drop_sck", 32'(sck), 32'd0);
    check("drop_cnt_sck", 32'(cnt_sck), 32'd0);
    check("drop_data_out", 32'(data_out), 32'd0);
    check("drop_data_valid", 32'(data_valid), 32'd0);
    check("drop_busy", 32'(busy), 32'd0);
    key_state = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("drop_no_valid", 32'(n_valid - v0), 32'd0);
    r0 = n_rise;
    frame_a(16'h3C96, 1'b0, lat, gaps, bav);
    check("after_drop_data", 32'(data_out), 32'h3C96);
    check("after_drop_latency", 32'(lat), 32'd186);
    check("after_drop_rises", 32'(n_rise - r0), 32'd16);

    // Asynchronous reset mid-SHIFT.
    adc_word = 16'h1111;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (cnt_sck != 5'd5 && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("rst_reached_5", 32'(cnt_sck), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_convst", 32'(convst), 32'd0);
    check("arst_cs", 32'(cs), 32'd1);
    check("arst_sck", 32'(sck), 32'd0);
    check("arst_cnt_sck", 32'(cnt_sck), 32'd0);
    check("arst_data_out", 32'(data_out), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame_a(16'h5A5A, 1'b0, lat, gaps, bav);
    check("post_rst_data", 32'(data_out), 32'h5A5A);
    check("post_rst_latency", 32'(lat), 32'd186);

    // Fast build: CLK_DIV=2, T_CONV=3.
    r0 = b_rise; c0 = b_cslow;
    b_word = 16'h0F0F;
    b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    lat = -1;
    for (int j = 1; j <= 200; j++) begin
      @(posedge clk);
      #1;
      if (b_valid) begin
        lat = j;
        break;
      end
    end
    check("fast_latency", 32'(lat), 32'd71);
    check("fast_data", 32'(b_data), 32'h0F0F);
    check("fast_busy_at_valid", 32'(b_busy), 32'd0);
    check("fast_cnt_sck", 32'(b_cnt), 32'd0);
    check("fast_rises", 32'(b_rise - r0), 32'd16);
    check("fast_cs_low", 32'(b_cslow - c0), 32'd68);
    check("fast_sck_period", 32'(b_period), 32'd4);
    @(posedge clk);
    #1;
    check("fast_valid_one_cycle", 32'(b_valid), 32'd0);
    check("fast_convst_idle", 32'(b_convst), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
